wb_port_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback path and the long-latency multiply/divide unit (MDU). MDU results are accepted through a valid/ready handshake, buffered in a small FIFO, and retired into free write-port cycles. Pipeline writes normally have priority. A starvation counter briefly stalls the pipeline so buffered MDU results always drain. The block sits between the MEM/WB stage register, the MDU and the register file, in place of a direct writeback connection. It also reports pending MDU destinations to the hazard unit.

---
 rtl/wb_port_arbiter_pkg.sv | 22 ++
 rtl/wb_result_fifo.sv | 62 ++++++
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 tb/tb_wb_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: register/data
// widths, the buffered MDU writeback entry, and the hazard-match helper.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // One buffered MDU writeback: destination register plus result value.
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } wb_entry_t;

  // True when a buffered destination collides with a decode source.
  // Register 0 is hard-wired and never creates a hazard.
  function automatic logic dest_hit(input logic [REG_W-1:0] dest,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt);
    return (dest != '0) && ((dest == rs) || (dest == rt));
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of pending MDU writebacks. Pointers carry one extra MSB so
// full and empty are told apart without a separate counter. Each slot
// also reports whether it is occupied and matches a decode source.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic [DEPTH-1:0] match
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  wb_entry_t        mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PTR_W'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset discards every buffered entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Entry storage; occupancy is tracked by the pointers, so no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [AW-1:0] off;
    assign off      = AW'(i) - rd_ptr[AW-1:0];
    assign match[i] = ({1'b0, off} < count) && dest_hit(mem[i].dest, id_rs, id_rt);
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback normally owns
// the port; buffered MDU results fill idle cycles, and a starvation
// counter forces a one-cycle pipeline stall so the FIFO always drains.
//
// MDU handshake: a result transfers on a rising edge where mdu_valid and
// mdu_ready are both high. mdu_ready depends only on registered FIFO
// occupancy, never on mdu_valid or on a same-cycle pop. The MDU must hold
// its offer stable until it transfers. A transfer to register 0 completes
// normally but is dropped rather than buffered.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_wb_writereg,
  input  logic [REG_W-1:0]  mem_wb_regdest,
  input  logic [DATA_W-1:0] mem_wb_wbvalue,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_regdest,
  input  logic [DATA_W-1:0] mdu_value,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  output logic              arb_pend_hit,
  output logic              arb_stall,
  output logic              wb_reg_en,
  output logic [REG_W-1:0]  wb_reg_addr,
  output logic [DATA_W-1:0] wb_reg_data
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             pipe_req;
  logic             pipe_grant;
  logic             fifo_grant;
  logic             push;
  logic             full;
  logic             empty;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic [DEPTH-1:0] match;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  assign mdu_ready    = !full;
  assign push         = mdu_valid && !full && (mdu_regdest != '0);
  assign push_entry   = '{dest: mdu_regdest, value: mdu_value};
  assign pipe_req     = mem_wb_writereg && (mem_wb_regdest != '0);
  assign arb_pend_hit = |match;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (fifo_grant),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .match      (match)
  );

  // Grant: forced drain beats pipeline, pipeline beats opportunistic drain.
  always_comb begin
    pipe_grant = 1'b0;
    fifo_grant = 1'b0;
    if (!reset) begin
      if (arb_stall)     fifo_grant = 1'b1;
      else if (pipe_req) pipe_grant = 1'b1;
      else if (!empty)   fifo_grant = 1'b1;
    end
  end

  // Write-port mux; idle port drives zeros.
  always_comb begin
    wb_reg_en   = 1'b0;
    wb_reg_addr = '0;
    wb_reg_data = '0;
    if (pipe_grant) begin
      wb_reg_en   = 1'b1;
      wb_reg_addr = mem_wb_regdest;
      wb_reg_data = mem_wb_wbvalue;
    end else if (fifo_grant) begin
      wb_reg_en   = 1'b1;
      wb_reg_addr = head.dest;
      wb_reg_data = head.value;
    end
  end

  // Denied-cycle count for a waiting head entry, saturating at the limit.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (fifo_grant || empty)  wait_cnt_next = '0;
    else if (wait_cnt != LIMIT) wait_cnt_next = wait_cnt + CNT_W'(1);
  end

  // Stall fires the cycle after the count reaches the limit; that cycle's pop clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      arb_stall <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      arb_stall <= (wait_cnt_next == LIMIT);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4). Inputs
// change 1ns after the rising edge; outputs are checked 3ns later.
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_wbvalue;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_regdest;
  logic [31:0] mdu_value;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        arb_pend_hit;
  logic        arb_stall;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_wb_writereg (mem_wb_writereg),
    .mem_wb_regdest  (mem_wb_regdest),
    .mem_wb_wbvalue  (mem_wb_wbvalue),
    .mdu_valid       (mdu_valid),
    .mdu_ready       (mdu_ready),
    .mdu_regdest     (mdu_regdest),
    .mdu_value       (mdu_value),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .arb_pend_hit    (arb_pend_hit),
    .arb_stall       (arb_stall),
    .wb_reg_en       (wb_reg_en),
    .wb_reg_addr     (wb_reg_addr),
    .wb_reg_data     (wb_reg_data)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, ".en"},   {31'b0, wb_reg_en}, {31'b0, en});
    check({tag, ".addr"}, {27'b0, wb_reg_addr}, {27'b0, addr});
    check({tag, ".data"}, wb_reg_data, data);
  endtask

  task automatic pipe(input logic req, input logic [4:0] dest, input logic [31:0] value);
    mem_wb_writereg = req;
    mem_wb_regdest  = dest;
    mem_wb_wbvalue  = value;
  endtask

  task automatic mdu(input logic valid, input logic [4:0] dest, input logic [31:0] value);
    mdu_valid   = valid;
    mdu_regdest = dest;
    mdu_value   = value;
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
    mdu(1'b0, 5'd0, 32'h0);
    id_rs = 5'd0;
    id_rt = 5'd0;

    // Reset holds the port idle even with a pipeline request present
    tick();
    tick();
    settle();
    check_wb("reset", 1'b0, 5'd0, 32'h0);
    check("reset.ready", {31'b0, mdu_ready}, 32'd1);
    check("reset.stall", {31'b0, arb_stall}, 32'd0);
    check("reset.pend",  {31'b0, arb_pend_hit}, 32'd0);

    // Pipeline write passes through in the same cycle
    tick();
    reset = 1'b0;
    settle();
    check_wb("pipe_pass", 1'b1, 5'd5, 32'hDEAD_BEEF);

    // MDU only: offer r7, not written in the accept cycle
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    mdu(1'b1, 5'd7, 32'h1234);
    settle();
    check("mdu_only.ready", {31'b0, mdu_ready}, 32'd1);
    check_wb("mdu_only.accept_cyc", 1'b0, 5'd0, 32'h0);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    check_wb("mdu_only.write", 1'b1, 5'd7, 32'h1234);
    tick();
    settle();
    check_wb("mdu_only.drained", 1'b0, 5'd0, 32'h0);

    // Hazard: r9 buffered behind a pipeline write, id_rs = 9
    tick();
    pipe(1'b1, 5'd3, 32'h33);
    mdu(1'b1, 5'd9, 32'h99);
    id_rs = 5'd9;
    settle();
    check("hazard.pre", {31'b0, arb_pend_hit}, 32'd0);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    check("hazard.hit", {31'b0, arb_pend_hit}, 32'd1);
    check_wb("hazard.pipe_prio", 1'b1, 5'd3, 32'h33);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    check_wb("hazard.mdu_write", 1'b1, 5'd9, 32'h99);
    check("hazard.hit_during_write", {31'b0, arb_pend_hit}, 32'd1);
    tick();
    settle();
    check("hazard.cleared", {31'b0, arb_pend_hit}, 32'd0);
    check_wb("hazard.idle", 1'b0, 5'd0, 32'h0);
    id_rs = 5'd0;

    // Full FIFO and starvation under continuous pipeline writes to r4
    tick();
    pipe(1'b1, 5'd4, 32'h44);
    mdu(1'b1, 5'd10, 32'hA);
    settle();
    check("full.c0.ready", {31'b0, mdu_ready}, 32'd1);
    tick();                                   // A accepted, head from here
    mdu(1'b1, 5'd11, 32'hB);
    settle();
    check("full.c1.ready", {31'b0, mdu_ready}, 32'd1);
    check("full.c1.stall", {31'b0, arb_stall}, 32'd0);
    check_wb("full.c1", 1'b1, 5'd4, 32'h44);
    tick();                                   // B accepted, FIFO full
    mdu(1'b1, 5'd12, 32'hC);
    settle();
    check("full.c2.ready", {31'b0, mdu_ready}, 32'd0);
    check("full.c2.stall", {31'b0, arb_stall}, 32'd0);
    tick();
    settle();
    check("full.c3.ready", {31'b0, mdu_ready}, 32'd0);
    check("full.c3.stall", {31'b0, arb_stall}, 32'd0);
    check_wb("full.c3", 1'b1, 5'd4, 32'h44);
    tick();
    settle();
    check("starve.c4.stall", {31'b0, arb_stall}, 32'd0);
    check_wb("starve.c4", 1'b1, 5'd4, 32'h44);
    tick();                                   // fifth cycle of A as head
    settle();
    check("starve.c5.stall", {31'b0, arb_stall}, 32'd1);
    check_wb("starve.c5", 1'b1, 5'd10, 32'hA);
    check("starve.c5.ready", {31'b0, mdu_ready}, 32'd0);
    tick();
    settle();
    check("starve.c6.stall", {31'b0, arb_stall}, 32'd0);
    check_wb("starve.c6.pipe_lands", 1'b1, 5'd4, 32'h44);
    check("starve.c6.ready", {31'b0, mdu_ready}, 32'd1);
    tick();                                   // held C accepted now
    mdu(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    check("drain.c7.ready", {31'b0, mdu_ready}, 32'd0);
    check_wb("drain.c7", 1'b1, 5'd11, 32'hB);
    tick();
    settle();
    check_wb("drain.c8.held_offer", 1'b1, 5'd12, 32'hC);
    check("drain.c8.ready", {31'b0, mdu_ready}, 32'd1);
    tick();
    settle();
    check_wb("drain.c9.empty", 1'b0, 5'd0, 32'h0);

    // r0: MDU dest 0 accepted but dropped
    tick();
    mdu(1'b1, 5'd0, 32'h77);
    settle();
    check("r0.mdu.ready", {31'b0, mdu_ready}, 32'd1);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    check_wb("r0.mdu.dropped", 1'b0, 5'd0, 32'h0);

    // r0: pipeline write to r0 leaves the port to the FIFO head
    tick();
    pipe(1'b1, 5'd0, 32'h55);
    mdu(1'b1, 5'd13, 32'hD);
    settle();
    check_wb("r0.pipe.empty_fifo", 1'b0, 5'd0, 32'h0);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    check_wb("r0.pipe.head_granted", 1'b1, 5'd13, 32'hD);
    tick();
    settle();
    check_wb("r0.pipe.drained", 1'b0, 5'd0, 32'h0);

    // Reset mid-drain: buffered r20 (seen via id_rt) is discarded
    tick();
    pipe(1'b1, 5'd1, 32'h11);
    mdu(1'b1, 5'd20, 32'h20);
    id_rt = 5'd20;
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    check("rst_mid.pend_rt", {31'b0, arb_pend_hit}, 32'd1);
    reset = 1'b1;
    #1;
    check_wb("rst_mid.async", 1'b0, 5'd0, 32'h0);
    check("rst_mid.pend", {31'b0, arb_pend_hit}, 32'd0);
    check("rst_mid.ready", {31'b0, mdu_ready}, 32'd1);
    tick();
    reset = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    check_wb("rst_mid.discarded", 1'b0, 5'd0, 32'h0);
    check("rst_mid.stall", {31'b0, arb_stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
